// File: rtl/pipeline_mem_stage_pkg.sv
// mem_pkg: shared constants, state encoding and helpers for the RV64 memory stage.
package mem_pkg;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;
    localparam logic [1:0] WB_ZERO = 2'b00;
    localparam logic [1:0] WB_PC4  = 2'b01;
    localparam logic [1:0] WB_ALU  = 2'b10;
    localparam logic [1:0] WB_MEM  = 2'b11;
    localparam int TO_W = 8;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        return sz == SZ_B ? 8'h01 : sz == SZ_H ? 8'h03 : sz == SZ_W ? 8'h0F : 8'hFF;
    endfunction
endpackage

// File: rtl/pipeline_mem_stage_if.sv
// pipeline_mem_stage_if: req/ack data-memory port between the memory stage and the data memory.
interface pipeline_mem_stage_if #(parameter int XLEN = 64);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [7:0]      dmem_wstrb;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;
    modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, input dmem_ack, dmem_rdata);
    modport slave  (input dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, output dmem_ack, dmem_rdata);
endinterface

// File: rtl/pipeline_mem_stage_align.sv
// mem_align_unit: byte-lane placement of store data/strobes, load extraction with extension, misalignment detection.
module mem_align_unit import mem_pkg::*; #(parameter int XLEN = 64) (
    input  logic [2:0]      funct3,
    input  logic [2:0]      off,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] wdata,
    output logic [7:0]      wstrb,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned
);
    logic [1:0]      sz;
    logic            sx;
    logic [XLEN-1:0] sh;
    always_comb begin
        sz = funct3[1:0];
        sx = ~funct3[2];
        sh = rdata >> {off, 3'b000};
        wdata = rs2 << {off, 3'b000};
        wstrb = size_mask(sz) << off;
        misaligned = (sz == SZ_H && off[0]) || (sz == SZ_W && |off[1:0]) || (sz == SZ_D && |off);
        load_data = sz == SZ_B ? {{(XLEN-8){sx & sh[7]}}, sh[7:0]} :
                    sz == SZ_H ? {{(XLEN-16){sx & sh[15]}}, sh[15:0]} :
                    sz == SZ_W ? {{(XLEN-32){sx & sh[31]}}, sh[31:0]} : sh;
    end
endmodule

// File: rtl/pipeline_mem_stage.sv
// pipeline_mem_stage: RV64 memory-access stage with IDLE/BUSY request FSM, timeout abort and MEM/WB register.
module pipeline_mem_stage import mem_pkg::*; #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_EX,
    input  logic [XLEN-1:0] alu_result_EX,
    input  logic [XLEN-1:0] rs2_data_EX,
    input  logic [4:0]      rd_EX,
    input  logic            reg_write_EX,
    input  logic [1:0]      rf_wr_sel_EX,
    input  logic            mem_read_EX,
    input  logic            mem_write_EX,
    input  logic [2:0]      funct3_EX,
    input  logic [XLEN-1:0] pc_EX,
    input  logic            flush_MEM,
    pipeline_mem_stage_if.master dmem,
    output logic            stall_MEM,
    output logic            misalign_MEM,
    output logic            bus_err_MEM,
    output logic [XLEN-1:0] alu_result_MEM,
    output logic [XLEN-1:0] mem_data_MEM,
    output logic [XLEN-1:0] pc_MEM,
    output logic [4:0]      rd_MEM,
    output logic            reg_write_MEM,
    output logic [1:0]      rf_wr_sel_MEM
);
    state_t          state_q;
    logic [TO_W-1:0] cnt_q;
    logic            flushed_q, rw_q, req_q, we_q;
    logic [2:0]      f3_q, off_q;
    logic [XLEN-1:0] alu_q, pc_q, addr_q, wdata_q;
    logic [4:0]      rd_q;
    logic [1:0]      sel_q;
    logic [7:0]      wstrb_q;
    logic            busy, mem_op, mis, go, timeout;
    logic [XLEN-1:0] wdata, load_data;
    logic [7:0]      wstrb;
    // One align unit serves both paths: EX fields when idle, captured fields while waiting for ack.
    mem_align_unit #(.XLEN(XLEN)) u_align (
        .funct3(busy ? f3_q : funct3_EX),
        .off(busy ? off_q : alu_result_EX[2:0]),
        .rs2(rs2_data_EX),
        .rdata(dmem.dmem_rdata),
        .wdata(wdata),
        .wstrb(wstrb),
        .load_data(load_data),
        .misaligned(mis)
    );
    assign busy    = state_q == BUSY;
    assign mem_op  = valid_EX & (mem_read_EX | mem_write_EX) & ~flush_MEM;
    assign go      = ~busy & mem_op & ~mis;
    assign timeout = busy & ~dmem.dmem_ack & (cnt_q == TO_W'(TIMEOUT - 1));
    assign stall_MEM = reset & (go | (busy & ~dmem.dmem_ack));
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_wstrb = wstrb_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            flushed_q      <= 1'b0;
            f3_q           <= '0;
            off_q          <= '0;
            alu_q          <= '0;
            pc_q           <= '0;
            rd_q           <= '0;
            rw_q           <= 1'b0;
            sel_q          <= '0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            misalign_MEM   <= 1'b0;
            bus_err_MEM    <= 1'b0;
            alu_result_MEM <= '0;
            mem_data_MEM   <= '0;
            pc_MEM         <= '0;
            rd_MEM         <= '0;
            reg_write_MEM  <= 1'b0;
            rf_wr_sel_MEM  <= '0;
        end else begin
            misalign_MEM   <= ~busy & mem_op & mis;
            bus_err_MEM    <= timeout;
            // Bubble unless a branch below loads a real instruction.
            alu_result_MEM <= '0;
            mem_data_MEM   <= '0;
            pc_MEM         <= '0;
            rd_MEM         <= '0;
            reg_write_MEM  <= 1'b0;
            rf_wr_sel_MEM  <= '0;
            if (!busy) begin
                if (go) begin
                    state_q   <= BUSY;
                    cnt_q     <= '0;
                    flushed_q <= 1'b0;
                    f3_q      <= funct3_EX;
                    off_q     <= alu_result_EX[2:0];
                    alu_q     <= alu_result_EX;
                    pc_q      <= pc_EX;
                    rd_q      <= rd_EX;
                    rw_q      <= reg_write_EX;
                    sel_q     <= rf_wr_sel_EX;
                    req_q     <= 1'b1;
                    we_q      <= mem_write_EX;
                    addr_q    <= {alu_result_EX[XLEN-1:3], 3'b000};
                    wdata_q   <= wdata;
                    wstrb_q   <= mem_write_EX ? wstrb : 8'h00;
                end else if (valid_EX & ~flush_MEM & ~mem_read_EX & ~mem_write_EX) begin
                    alu_result_MEM <= alu_result_EX;
                    pc_MEM         <= pc_EX;
                    rd_MEM         <= rd_EX;
                    reg_write_MEM  <= reg_write_EX;
                    rf_wr_sel_MEM  <= rf_wr_sel_EX;
                end
            end else if (dmem.dmem_ack) begin
                state_q <= IDLE;
                req_q   <= 1'b0;
                if (!(flushed_q | flush_MEM)) begin
                    alu_result_MEM <= alu_q;
                    mem_data_MEM   <= we_q ? '0 : load_data;
                    pc_MEM         <= pc_q;
                    rd_MEM         <= rd_q;
                    reg_write_MEM  <= rw_q & ~we_q;
                    rf_wr_sel_MEM  <= sel_q;
                end
            end else if (timeout) begin
                state_q <= IDLE;
                req_q   <= 1'b0;
            end else begin
                cnt_q     <= cnt_q + TO_W'(1);
                flushed_q <= flushed_q | flush_MEM;
            end
        end
    end
endmodule
